// File: rtl/jtpang_pkg.sv
// Shared definitions for the pang object-attribute DMA: FSM encoding and
// the default transfer geometry.
package jtpang_pkg;

  localparam int OBJ_LEN = 512;
  localparam int OBJ_AW  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COPY = 2'd2,
    REL  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/jtpang_objdma_edge.sv
// Rising-edge detector for the CPU DMA trigger, sampled on cen, with a
// single pending latch that remembers one edge seen while a copy is busy.
module jtpang_objdma_edge
  import jtpang_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic i_din,
  input  logic i_busy,
  output logic o_trig
);

  logic r_last;
  logic r_pend;
  logic w_rise;

  assign w_rise = i_din & ~r_last;
  // Fresh edge or a remembered one; only meaningful to the FSM while idle.
  assign o_trig = cen & (w_rise | r_pend);

  // Track the previous trigger level and the pending flag on cen ticks.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    if (rst) begin
      r_last <= 1'b0;
      r_pend <= 1'b0;
    end else if (cen) begin
      r_last <= i_din;
      // While idle the FSM consumes the trigger this tick, so the latch is
      // dropped; while busy an edge only sets it (a flag, not a counter).
      if (!i_busy)     r_pend <= 1'b0;
      else if (w_rise) r_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/jtpang_objdma.sv
// Object-attribute DMA: on a CPU trigger, take the Z80 bus, copy LEN bytes
// from the CPU object RAM window into the renderer's object buffer, then
// hand the bus back. busy tells the renderer to skip drawing meanwhile.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int AW    = OBJ_AW,
  parameter int LEN   = OBJ_LEN,
  parameter int RDLAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_data,
  output logic [AW-1:0] dst_addr,
  output logic [7:0]    dst_data,
  output logic          dst_we,
  output logic          busy
);

  if (RDLAT != 1) begin : g_bad_rdlat
    $error("jtpang_objdma: only RDLAT=1 is supported");
  end
  if (LEN < 1 || LEN > (1 << AW)) begin : g_bad_len
    $error("jtpang_objdma: LEN must be in 1..2**AW");
  end

  // One extra bit so the end-of-copy value LEN never aliases to 0.
  localparam logic [AW:0] CNT_END = (AW+1)'(LEN);

  dma_state_t    r_state,    w_state_nxt;
  logic          r_busrq,    w_busrq_nxt;
  logic          r_busy,     w_busy_nxt;
  logic [AW:0]   r_cnt,      w_cnt_nxt;
  logic [AW-1:0] r_src_addr, w_src_addr_nxt;
  logic          r_rd_vld,   w_rd_vld_nxt;
  logic          r_we,       w_we_nxt;
  logic [AW-1:0] r_dst_addr, w_dst_addr_nxt;
  logic [7:0]    r_dst_data, w_dst_data_nxt;
  logic          w_trig;
  logic          w_can_issue;

  jtpang_objdma_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .i_din  (dma_go),
    .i_busy (r_busy),
    .o_trig (w_trig)
  );

  // A new read may go out while the bus is held and bytes remain.
  assign w_can_issue = ~busak_n & (r_cnt != CNT_END);

  // Next-state and next-output logic; everything holds when cen is low.
  always_comb begin
    // NOTE: every output of this block is given its hold value first, so no
    // path through the case/if tree can leave one unassigned (no latches).
    w_state_nxt    = r_state;
    w_busrq_nxt    = r_busrq;
    w_busy_nxt     = r_busy;
    w_cnt_nxt      = r_cnt;
    w_src_addr_nxt = r_src_addr;
    w_rd_vld_nxt   = r_rd_vld;
    w_we_nxt       = r_we;
    w_dst_addr_nxt = r_dst_addr;
    w_dst_data_nxt = r_dst_data;
    if (cen) begin
      w_we_nxt = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_trig) begin
            w_state_nxt  = REQ;
            w_busy_nxt   = 1'b1;
            w_busrq_nxt  = 1'b1;
            w_cnt_nxt    = '0;
            w_rd_vld_nxt = 1'b0;
          end
        end
        REQ: begin
          // The first read goes out on the acknowledge tick itself.
          if (!busak_n) begin
            w_state_nxt    = COPY;
            w_src_addr_nxt = r_cnt[AW-1:0];
            w_rd_vld_nxt   = 1'b1;
            w_cnt_nxt      = r_cnt + 1'b1;
          end
        end
        COPY: begin
          // The byte read last tick is owed a write whatever busak_n does.
          if (r_rd_vld) begin
            w_we_nxt       = 1'b1;
            w_dst_addr_nxt = r_src_addr;
            w_dst_data_nxt = src_data;
          end
          w_rd_vld_nxt = 1'b0;
          if (w_can_issue) begin
            w_src_addr_nxt = r_cnt[AW-1:0];
            w_rd_vld_nxt   = 1'b1;
            w_cnt_nxt      = r_cnt + 1'b1;
          end
          if (r_cnt == CNT_END && r_rd_vld) begin
            w_state_nxt = REL;
            w_busrq_nxt = 1'b0;
          end
        end
        REL: begin
          if (busak_n) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      endcase
    end
  end

  // State and output registers; reset wins over cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busrq    <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_src_addr <= '0;
      r_rd_vld   <= 1'b0;
      r_we       <= 1'b0;
      r_dst_addr <= '0;
      r_dst_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busrq    <= w_busrq_nxt;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
      r_src_addr <= w_src_addr_nxt;
      r_rd_vld   <= w_rd_vld_nxt;
      r_we       <= w_we_nxt;
      r_dst_addr <= w_dst_addr_nxt;
      r_dst_data <= w_dst_data_nxt;
    end
  end

  assign busrq    = r_busrq;
  assign busy     = r_busy;
  assign src_addr = r_src_addr;
  assign dst_addr = r_dst_addr;
  assign dst_data = r_dst_data;
  // The buffer commits on the next cen edge, so the strobe is confined to
  // the single clk where cen is high.
  assign dst_we   = r_we & cen;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed testbench for jtpang_objdma: a combinational source RAM, a
// destination buffer written on dst_we, and a Z80-like bus arbiter.
module tb_jtpang_objdma;

  localparam int AW  = 9;
  localparam int LEN = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          dma_go = 1'b0;
  logic          busak_n;
  logic          busrq, dst_we, busy;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    src_data, dst_data;

  logic [7:0] src_mem [LEN];
  logic [7:0] dst_mem [LEN];

  int checks = 0;
  int failures = 0;

  // Monitor-owned counters, cleared through the clr_req/clr_seen handshake.
  int n_wr = 0, ord_err = 0, we_nocen = 0, rq_rise = 0;
  int clr_req = 0, clr_seen = 0;
  logic busrq_q = 1'b0;

  int cen_div = 1, cen_ph = 0;

  // Bus acknowledge: manual from the tests or automatic from the arbiter.
  logic bus_auto = 1'b0, man_busak_n = 1'b1, arb_busak_n = 1'b1;
  int req_age = 0, pause_at = -1, pause_len = 0, pause_req = 0, pause_seen = 0;
  int p_at = -1, p_left = 0, p_tick = 0, snap3 = 0, snap_end = 0;

  assign busak_n  = bus_auto ? arb_busak_n : man_busak_n;
  assign src_data = src_mem[src_addr];

  jtpang_objdma dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .dma_go   (dma_go),
    .busak_n  (busak_n),
    .busrq    (busrq),
    .src_addr (src_addr),
    .src_data (src_data),
    .dst_addr (dst_addr),
    .dst_data (dst_data),
    .dst_we   (dst_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // cen high for one clk out of every cen_div, changed away from posedge.
  always @(negedge clk) begin
    if (cen_ph + 1 >= cen_div) cen_ph = 0;
    else cen_ph = cen_ph + 1;
    cen = (cen_ph == 0);
  end

  // Destination buffer, write ordering and strobe-qualification monitor.
  always @(posedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      n_wr = 0; ord_err = 0; we_nocen = 0; rq_rise = 0;
      for (int i = 0; i < LEN; i++) dst_mem[i] = ~(8'(i) ^ 8'h5A);
    end else if (dst_we) begin
      if (!cen) we_nocen++;
      if (dst_addr != AW'(n_wr % LEN)) ord_err++;
      dst_mem[dst_addr] = dst_data;
      n_wr++;
    end
    if (busrq && !busrq_q) rq_rise++;
    busrq_q = busrq;
  end

  // Advance to just after the next cen edge.
  task automatic tick();
    @(posedge clk);
    while (cen !== 1'b1) @(posedge clk);
    #1;
  endtask

  // Arbiter: grants two cen after busrq, releases once busrq drops, and can
  // withdraw the grant for pause_len ticks once pause_at writes are done.
  always begin
    tick();
    if (pause_req != pause_seen) begin
      pause_seen = pause_req;
      p_at = pause_at;
    end
    if (!bus_auto) begin
      arb_busak_n = 1'b1;
      req_age = 0;
    end else if (p_left > 0) begin
      p_left--;
      p_tick++;
      if (p_tick == 3) snap3 = n_wr;
      if (p_left == 0) begin
        snap_end = n_wr;
        arb_busak_n = 1'b0;
      end
    end else if (busrq) begin
      if (arb_busak_n) begin
        req_age++;
        if (req_age >= 2) arb_busak_n = 1'b0;
      end else if (p_at >= 0 && n_wr >= p_at) begin
        arb_busak_n = 1'b1;
        p_left = pause_len;
        p_tick = 0;
        p_at = -1;
      end
    end else begin
      req_age = 0;
      arb_busak_n = 1'b1;
    end
  end

  task automatic prep();
    clr_req++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    tick();
    dma_go = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_wr < target && k < budget) begin tick(); k++; end
    ok = (n_wr >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while (!(busy === 1'b0 && busrq === 1'b0 && busak_n === 1'b1) && k < budget) begin
      tick(); k++;
    end
    ok = (busy === 1'b0 && busrq === 1'b0);
  endtask

  function automatic int data_errs();
    int e = 0;
    for (int i = 0; i < LEN; i++) if (dst_mem[i] !== (8'(i) ^ 8'h5A)) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busrq !== 1'b0) begin failures++; $display("FAIL rst_busrq: got %b want 0", busrq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (dst_we !== 1'b0) begin failures++; $display("FAIL rst_dst_we: got %b want 0", dst_we); end
    checks++; if (src_addr !== '0) begin failures++; $display("FAIL rst_src_addr: got %0h want 0", src_addr); end
    checks++; if (dst_addr !== '0) begin failures++; $display("FAIL rst_dst_addr: got %0h want 0", dst_addr); end
    checks++; if (dst_data !== 8'h00) begin failures++; $display("FAIL rst_dst_data: got %0h want 0", dst_data); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int k;
    bus_auto = 1'b0; man_busak_n = 1'b1;
    prep();
    dma_go = 1'b1;
    tick();
    checks++; if (busrq !== 1'b1) begin failures++; $display("FAIL basic_busrq_lat: got %b want 1", busrq); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_set: got %b want 1", busy); end
    dma_go = 1'b0;
    tick(); tick();
    man_busak_n = 1'b0;
    k = 0;
    do begin tick(); k++; end while (dst_we !== 1'b1 && k < 10);
    checks++; if (k != 2) begin failures++; $display("FAIL basic_ack_to_we: got %0d cen want 2", k); end
    k = 0;
    while (busrq === 1'b1 && k < 2000) begin tick(); k++; end
    checks++; if (k != LEN - 1) begin failures++; $display("FAIL basic_copy_ticks: got %0d want %0d", k, LEN - 1); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rel: got %b want 1", busy); end
    tick();
    checks++; if (n_wr != LEN) begin failures++; $display("FAIL basic_writes: got %0d want %0d", n_wr, LEN); end
    man_busak_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_clr: got %b want 0", busy); end
    checks++; if (data_errs() != 0) begin failures++; $display("FAIL basic_data: got %0d bad bytes want 0", data_errs()); end
    checks++; if (ord_err != 0) begin failures++; $display("FAIL basic_order: got %0d out-of-order want 0", ord_err); end
  endtask

  task automatic test_held();
    bit ok;
    bus_auto = 1'b1;
    prep();
    dma_go = 1'b1;
    repeat (1000) tick();
    dma_go = 1'b0;
    wait_idle(100, ok);
    repeat (20) tick();
    checks++; if (!ok) begin failures++; $display("FAIL held_idle: busy=%b busrq=%b want idle", busy, busrq); end
    checks++; if (n_wr != LEN) begin failures++; $display("FAIL held_writes: got %0d want %0d", n_wr, LEN); end
    checks++; if (rq_rise != 1) begin failures++; $display("FAIL held_busrq_count: got %0d want 1", rq_rise); end
    checks++; if (data_errs() != 0) begin failures++; $display("FAIL held_data: got %0d bad bytes want 0", data_errs()); end
  endtask

  task automatic test_retrigger();
    bit ok;
    prep();
    pulse_go();
    wait_writes(100, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL retrig_wait100: got %0d writes want 100", n_wr); end
    pulse_go();
    wait_writes(300, 1000, ok);
    pulse_go();
    wait_writes(2 * LEN, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL retrig_wait_all: got %0d writes want %0d", n_wr, 2 * LEN); end
    wait_idle(100, ok);
    repeat (30) tick();
    checks++; if (n_wr != 2 * LEN) begin failures++; $display("FAIL retrig_writes: got %0d want %0d", n_wr, 2 * LEN); end
    checks++; if (rq_rise != 2) begin failures++; $display("FAIL retrig_busrq_count: got %0d want 2", rq_rise); end
    checks++; if (ord_err != 0) begin failures++; $display("FAIL retrig_order: got %0d want 0", ord_err); end
    checks++; if (data_errs() != 0) begin failures++; $display("FAIL retrig_data: got %0d bad bytes want 0", data_errs()); end
  endtask

  task automatic test_pause();
    bit ok;
    prep();
    pause_at = 200; pause_len = 10; pause_req++;
    pulse_go();
    wait_writes(LEN, 2000, ok);
    wait_idle(100, ok);
    checks++; if (snap3 < 201 || snap3 > 202) begin failures++; $display("FAIL pause_owed: got %0d writes want 201..202", snap3); end
    checks++; if (snap_end != snap3) begin failures++; $display("FAIL pause_quiet: got %0d writes want %0d", snap_end, snap3); end
    checks++; if (n_wr != LEN) begin failures++; $display("FAIL pause_writes: got %0d want %0d", n_wr, LEN); end
    checks++; if (ord_err != 0) begin failures++; $display("FAIL pause_order: got %0d want 0", ord_err); end
    checks++; if (data_errs() != 0) begin failures++; $display("FAIL pause_data: got %0d bad bytes want 0", data_errs()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    prep();
    pulse_go();
    wait_writes(300, 1000, ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busrq !== 1'b0) begin failures++; $display("FAIL midrst_busrq: got %b want 0", busrq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (dst_we !== 1'b0) begin failures++; $display("FAIL midrst_dst_we: got %b want 0", dst_we); end
    rst = 1'b0;
    repeat (4) tick();
    prep();
    pulse_go();
    wait_writes(LEN, 2000, ok);
    wait_idle(100, ok);
    repeat (10) tick();
    checks++; if (n_wr != LEN) begin failures++; $display("FAIL midrst_writes: got %0d want %0d", n_wr, LEN); end
    checks++; if (rq_rise != 1) begin failures++; $display("FAIL midrst_busrq_count: got %0d want 1", rq_rise); end
    checks++; if (ord_err != 0) begin failures++; $display("FAIL midrst_order: got %0d want 0", ord_err); end
    checks++; if (data_errs() != 0) begin failures++; $display("FAIL midrst_data: got %0d bad bytes want 0", data_errs()); end
  endtask

  task automatic test_cen_gating();
    bit ok;
    cen_div = 4;
    repeat (8) @(posedge clk);
    prep();
    pulse_go();
    wait_writes(LEN, 2000, ok);
    wait_idle(100, ok);
    checks++; if (n_wr != LEN) begin failures++; $display("FAIL cen_writes: got %0d want %0d", n_wr, LEN); end
    checks++; if (we_nocen != 0) begin failures++; $display("FAIL cen_we_gated: got %0d strobes without cen want 0", we_nocen); end
    checks++; if (ord_err != 0) begin failures++; $display("FAIL cen_order: got %0d want 0", ord_err); end
    checks++; if (data_errs() != 0) begin failures++; $display("FAIL cen_data: got %0d bad bytes want 0", data_errs()); end
    cen_div = 1;
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) src_mem[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_basic();
    test_held();
    test_retrigger();
    test_pause();
    test_reset_mid();
    test_cen_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
